// File: rtl/vga_pkg.sv
// vga_pkg
//   Definitions shared by the video fetch path and the sync generator.
//   - VGA_H_DISPLAY : first horizontal-blank column. The fetch window opens here.
//   - VGA_H_MAX     : last column of a line. This column is the line boundary.
//   - VGA_V_DISPLAY : first vertical-blank line.
//   - fetch_state_t : states of the fetch-window FSM.
package vga_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_MAX     = 799;
  localparam int VGA_V_DISPLAY = 480;

  typedef enum logic [1:0] {
    FS_CLOSED    = 2'd0,
    FS_OPEN      = 2'd1,
    FS_EXHAUSTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin priority pick over N_REQ request lines. The search starts at
//   the rr pointer and wraps modulo N_REQ. The first asserted request wins.
//   The pointer itself is kept by the parent.
//   Ports:
//     req   in  N_REQ  request vector
//     en    in  1      enable; when low, no grant is issued
//     rr    in  IW     requester index that has the highest priority
//     grant out N_REQ  one-hot grant (all zero when nothing is picked)
//     idx   out IW     index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  input  logic [IW-1:0]    rr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  always_comb begin
    logic found;
    int   c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      c = (int'(rr) + k) % N_REQ;
      if (en && !found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/vga_fetch_scheduler.sv
// vga_fetch_scheduler
//   This module shares one single-port pattern/tile memory between N_REQ
//   pixel-pipeline requesters. Fetches happen only when video is not active:
//   during the horizontal blank of each line and during all of vertical blank.
//   Requesters are served round-robin. The number of grants per line is
//   limited. Lines whose fetches did not finish by the line boundary are
//   reported on a sticky flag.
//   Ports:
//     clk, reset          pixel clock; synchronous active-high reset
//     hpos, vpos          beam position from the sync generator
//     req, req_addr       request levels and packed addresses (slice i = requester i)
//     grant               one-hot grant (combinational)
//     mem_en, mem_addr    memory read port (combinational from the grant)
//     mem_rdata           read data, valid one cycle after mem_en
//     rsp_valid, rsp_id   response strobe and requester index, one cycle after the grant
//     rsp_data            mem_rdata passed through
//     miss, miss_clr      sticky late-fetch flag and its clear
module vga_fetch_scheduler
  import vga_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int AW           = 12,
  parameter int DW           = 8,
  parameter int H_DISPLAY    = VGA_H_DISPLAY,
  parameter int H_MAX        = VGA_H_MAX,
  parameter int V_DISPLAY    = VGA_V_DISPLAY,
  parameter int FETCH_BUDGET = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*AW-1:0]      req_addr,
  output logic [N_REQ-1:0]         grant,
  output logic                     mem_en,
  output logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [DW-1:0]            rsp_data,
  output logic                     miss,
  input  logic                     miss_clr
);

  localparam int         IW        = $clog2(N_REQ);
  localparam logic [9:0] H_DISP_C  = 10'(H_DISPLAY);
  localparam logic [9:0] H_MAX_C   = 10'(H_MAX);
  localparam logic [9:0] V_DISP_C  = 10'(V_DISPLAY);
  localparam logic [7:0] BUDGET_C  = 8'(FETCH_BUDGET);
  localparam logic [7:0] BUDGET_LC = 8'(FETCH_BUDGET - 1);

  fetch_state_t  state_reg, state_next;
  logic [7:0]    budget_reg;
  logic [IW-1:0] rr_reg, rr_next;
  logic          rsp_valid_reg;
  logic [IW-1:0] rsp_id_reg;
  logic          miss_reg;

  logic          win, lb;
  logic          arb_en, any_grant;
  logic [IW-1:0] grant_idx;
  logic [AW-1:0] addr_arr [N_REQ];

  assign win = (hpos >= H_DISP_C) || (vpos >= V_DISP_C);
  assign lb  = (hpos == H_MAX_C);

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_addr
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
    end
  endgenerate

  // The budget compare is a second guard. It also keeps the counter from
  // wrapping if the FSM is in OPEN while the count is already at the limit.
  assign arb_en = (state_reg == FS_OPEN) && win && !reset && (budget_reg < BUDGET_C);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req   (req),
    .en    (arb_en),
    .rr    (rr_reg),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign any_grant = |grant;
  assign mem_en    = any_grant;
  assign mem_addr  = any_grant ? addr_arr[grant_idx] : '0;

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = mem_rdata;
  assign miss      = miss_reg;

  // FSM next state. A line boundary takes priority over budget exhaustion.
  // This lets vertical blank fetch continuously, line after line.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FS_CLOSED: begin
        if (win) state_next = FS_OPEN;
      end
      FS_OPEN: begin
        if (!win) state_next = FS_CLOSED;
        else if (!lb && any_grant && budget_reg == BUDGET_LC) state_next = FS_EXHAUSTED;
      end
      FS_EXHAUSTED: begin
        if (!win) state_next = FS_CLOSED;
        else if (lb) state_next = FS_OPEN;
      end
      default: state_next = FS_CLOSED;
    endcase
  end

  always_comb begin
    rr_next = rr_reg;
    if (any_grant) begin
      if (int'(grant_idx) == N_REQ - 1) rr_next = '0;
      else rr_next = grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= FS_CLOSED;
    else state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      budget_reg    <= '0;
      rr_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      miss_reg      <= 1'b0;
    end else begin
      if (lb) budget_reg <= '0;
      else if (any_grant) budget_reg <= budget_reg + 8'd1;
      rr_reg        <= rr_next;
      rsp_valid_reg <= any_grant;
      rsp_id_reg    <= grant_idx;
      // A late fetch counts only in active lines. When set and clear happen
      // in the same cycle, set wins, so the miss is not lost.
      if (lb && (vpos < V_DISP_C) && (|req) && !any_grant) miss_reg <= 1'b1;
      else if (miss_clr) miss_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// tb_vga_fetch_scheduler
//   Directed bench for vga_fetch_scheduler. Instance dut_a uses the default
//   budget (128). Instance dut_b uses a budget of 4. Both instances share the
//   beam position and request inputs. Each instance has its own memory model,
//   which returns addr[7:0] ^ 8'hA5 one cycle after mem_en.
module tb_vga_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic [3:0]  req;
  logic [47:0] req_addr;
  logic        miss_clr;

  logic [3:0]  a_grant, b_grant;
  logic        a_mem_en, b_mem_en;
  logic [11:0] a_mem_addr, b_mem_addr;
  logic [7:0]  a_rdata, b_rdata;
  logic        a_rsp_valid, b_rsp_valid;
  logic [1:0]  a_rsp_id, b_rsp_id;
  logic [7:0]  a_rsp_data, b_rsp_data;
  logic        a_miss, b_miss;

  int n_vec  = 0;
  int n_miss = 0;

  // Hand-computed addresses per requester and the read data the memory model
  // returns for them (low byte xor A5).
  logic [11:0] addr_c [4] = '{12'h123, 12'h234, 12'h345, 12'h456};
  logic [7:0]  data_c [4] = '{8'h86, 8'h91, 8'hE0, 8'hF3};

  always #5 clk = ~clk;

  vga_fetch_scheduler dut_a (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .req(req), .req_addr(req_addr),
    .grant(a_grant), .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_rdata(a_rdata),
    .rsp_valid(a_rsp_valid), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data),
    .miss(a_miss), .miss_clr(miss_clr)
  );

  vga_fetch_scheduler #(.FETCH_BUDGET(4)) dut_b (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .req(req), .req_addr(req_addr),
    .grant(b_grant), .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_rdata(b_rdata),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
    .miss(b_miss), .miss_clr(miss_clr)
  );

  always @(posedge clk) begin
    if (a_mem_en) a_rdata <= a_mem_addr[7:0] ^ 8'hA5;
    if (b_mem_en) b_rdata <= b_mem_addr[7:0] ^ 8'hA5;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (hpos=%0d vpos=%0d)", tag, obs, exp, hpos, vpos);
    end
  endtask

  // Wait for one clock edge, then apply the inputs for the new cycle and let
  // the combinational paths settle. Outputs are checked well before the next edge.
  task automatic step(input int h, input int v, input logic [3:0] r,
                      input logic rst, input logic clr);
    @(posedge clk);
    #1;
    hpos     = 10'(h);
    vpos     = 10'(v);
    req      = r;
    reset    = rst;
    miss_clr = clr;
    #1;
  endtask

  task automatic pulse_reset();
    step(0, 0, 4'b0000, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset    = 1'b1;
    hpos     = '0;
    vpos     = '0;
    req      = '0;
    miss_clr = 1'b0;
    req_addr = {addr_c[3], addr_c[2], addr_c[1], addr_c[0]};
    a_rdata  = '0;
    b_rdata  = '0;
    pulse_reset();
    step(0, 0, 4'b0000, 1'b0, 1'b0);
    check("rst_grant", a_grant, 0);
    check("rst_mem_en", a_mem_en, 0);
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_rsp_id", a_rsp_id, 0);
    check("rst_miss", a_miss, 0);
    check("rst_rr", dut_a.rr_reg, 0);

    // 1: the window opens at column 640. In that first window column the FSM
    // leaves CLOSED. After that, requester 0 is granted on every cycle.
    pulse_reset();
    for (int h = 630; h <= 660; h++) begin
      step(h, 10, 4'b0001, 1'b0, 1'b0);
      if (h < 640) check("t1_idle_grant", a_grant, 0);
      if (h >= 641) begin
        check("t1_grant", a_grant, 4'b0001);
        check("t1_mem_en", a_mem_en, 1);
        check("t1_mem_addr", a_mem_addr, addr_c[0]);
      end
      if (h >= 642) begin
        check("t1_rsp_valid", a_rsp_valid, 1);
        check("t1_rsp_id", a_rsp_id, 0);
        check("t1_rsp_data", a_rsp_data, data_c[0]);
      end
    end

    // 2: round-robin order with all four requests held.
    pulse_reset();
    step(640, 20, 4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(641 + k, 20, 4'b1111, 1'b0, 1'b0);
      check("t2_grant", a_grant, 4'b0001 << (k % 4));
      check("t2_mem_addr", a_mem_addr, addr_c[k % 4]);
      if (k > 0) begin
        check("t2_rsp_id", a_rsp_id, (k - 1) % 4);
        check("t2_rsp_data", a_rsp_data, data_c[(k - 1) % 4]);
      end
    end

    // 3a: budget of 4 in an active line. Grants stop until the boundary.
    pulse_reset();
    cnt = 0;
    for (int h = 640; h <= 650; h++) begin
      step(h, 30, 4'b0010, 1'b0, 1'b0);
      if (b_grant != 4'b0000) cnt++;
    end
    check("t3_grant_count", cnt, 4);
    step(798, 30, 4'b0010, 1'b0, 1'b0);
    check("t3_exhausted", b_grant, 0);
    step(799, 30, 4'b0010, 1'b0, 1'b0);
    check("t3_lb_nogrant", b_grant, 0);
    step(0, 31, 4'b0010, 1'b0, 1'b0);
    check("t3_active_nogrant", b_grant, 0);

    // 3b: the same case in vblank. Grants resume right after the boundary.
    pulse_reset();
    cnt = 0;
    for (int h = 640; h <= 650; h++) begin
      step(h, 480, 4'b0010, 1'b0, 1'b0);
      if (b_grant != 4'b0000) cnt++;
    end
    check("t3v_grant_count", cnt, 4);
    step(799, 480, 4'b0010, 1'b0, 1'b0);
    check("t3v_lb_nogrant", b_grant, 0);
    step(0, 481, 4'b0010, 1'b0, 1'b0);
    check("t3v_resume_grant", b_grant, 4'b0010);
    check("t3v_resume_addr", b_mem_addr, addr_c[1]);
    step(1, 481, 4'b0010, 1'b0, 1'b0);
    check("t3v_rsp_valid", b_rsp_valid, 1);
    check("t3v_rsp_id", b_rsp_id, 1);

    // 4: the miss flag is set, then cleared, then set and cleared in the same cycle.
    pulse_reset();
    for (int h = 640; h <= 644; h++) step(h, 100, 4'b1000, 1'b0, 1'b0);
    step(799, 100, 4'b1000, 1'b0, 1'b0);
    check("t4_lb_nogrant", b_grant, 0);
    check("t4_miss_before", b_miss, 0);
    step(0, 101, 4'b1000, 1'b0, 1'b0);
    check("t4_miss_set", b_miss, 1);
    step(1, 101, 4'b1000, 1'b0, 1'b1);
    check("t4_miss_hold", b_miss, 1);
    step(2, 101, 4'b1000, 1'b0, 1'b0);
    check("t4_miss_cleared", b_miss, 0);
    step(799, 101, 4'b1000, 1'b0, 1'b1);
    check("t4_lb2_nogrant", b_grant, 0);
    step(0, 102, 4'b1000, 1'b0, 1'b0);
    check("t4_set_wins", b_miss, 1);

    // 5: reset is asserted on a grant cycle.
    pulse_reset();
    step(640, 40, 4'b1111, 1'b0, 1'b0);
    step(698, 40, 4'b1111, 1'b0, 1'b0);
    check("t5_grant0", a_grant, 4'b0001);
    step(699, 40, 4'b1111, 1'b0, 1'b0);
    check("t5_grant1", a_grant, 4'b0010);
    step(700, 40, 4'b1111, 1'b1, 1'b0);
    check("t5_rst_grant", a_grant, 0);
    check("t5_rst_mem_en", a_mem_en, 0);
    check("t5_prev_rsp", a_rsp_valid, 1);
    step(701, 40, 4'b1111, 1'b0, 1'b0);
    check("t5_rsp_valid", a_rsp_valid, 0);
    check("t5_rsp_id", a_rsp_id, 0);
    check("t5_grant", a_grant, 0);
    check("t5_rr", dut_a.rr_reg, 0);
    check("t5_budget", dut_a.budget_reg, 0);
    step(702, 40, 4'b1111, 1'b0, 1'b0);
    check("t5_resume", a_grant, 4'b0001);
    check("t5_resume_addr", a_mem_addr, addr_c[0]);

    // 6: a grant on the last window column. Its response comes at hpos=0.
    pulse_reset();
    step(640, 200, 4'b0100, 1'b0, 1'b0);
    step(798, 200, 4'b0100, 1'b0, 1'b0);
    check("t6_grant798", a_grant, 4'b0100);
    step(799, 200, 4'b0100, 1'b0, 1'b0);
    check("t6_grant799", a_grant, 4'b0100);
    check("t6_addr799", a_mem_addr, addr_c[2]);
    step(0, 201, 4'b0100, 1'b0, 1'b0);
    check("t6_rsp_valid", a_rsp_valid, 1);
    check("t6_rsp_id", a_rsp_id, 2);
    check("t6_rsp_data", a_rsp_data, data_c[2]);
    check("t6_no_grant", a_grant, 0);
    check("t6_no_miss", a_miss, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
